// File: rtl/ps2_mouse_packet.sv
// PS/2 stream-mode mouse packet assembler.
// Collects three received bytes into X/Y movement and button state, drops
// bytes that cannot start a packet, and aborts a packet after an inter-byte
// timeout. Optional build macro: MOUSE_OVF_CLAMP_EN (saturate X/Y to +/-255
// when the packet's overflow bit is set).
module ps2_mouse_packet #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned TIMEOUT_W      = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    output logic [8:0] xm,
    output logic [8:0] ym,
    output logic [2:0] btnm,
    output logic       m_done_tick,
    output logic       sync_err
);

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } state_t;

    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    // Byte 0 fields kept: {y_sign, x_sign, middle, right, left}
    logic [4:0]           b0_q, b0_d;
    logic [7:0]           b1_q, b1_d;
    logic [8:0]           xm_q, xm_d;
    logic [8:0]           ym_q, ym_d;
    logic [2:0]           btnm_q, btnm_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 expired_c;
`ifdef MOUSE_OVF_CLAMP_EN
    // Byte 0 overflow flags: {y_ovf, x_ovf}
    logic [1:0]           ovf_q, ovf_d;

    // Saturate an axis to +/-255 when its overflow flag is set.
    function automatic logic [8:0] axis_val(input logic sgn, input logic ovf,
                                            input logic [7:0] mag);
        if (ovf) begin
            return sgn ? 9'h101 : 9'h0FF;
        end
        return {sgn, mag};
    endfunction
`endif

    assign expired_c = (cnt_q == CNT_LAST);

    // State, counter, captured bytes and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_B0;
            cnt_q   <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            xm_q    <= '0;
            ym_q    <= '0;
            btnm_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MOUSE_OVF_CLAMP_EN
            ovf_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            xm_q    <= xm_d;
            ym_q    <= ym_d;
            btnm_q  <= btnm_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef MOUSE_OVF_CLAMP_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state logic: byte alignment, packet assembly and timeout abort.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        xm_d    = xm_q;
        ym_d    = ym_q;
        btnm_d  = btnm_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef MOUSE_OVF_CLAMP_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            WAIT_B0: begin
                cnt_d = '0;
                if (rx_done_tick) begin
                    // Only a byte with bit 3 set can be the first of a packet.
                    if (rx_data[3]) begin
                        b0_d    = {rx_data[5:4], rx_data[2:0]};
`ifdef MOUSE_OVF_CLAMP_EN
                        ovf_d   = rx_data[7:6];
`endif
                        state_d = WAIT_B1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT_B1: begin
                if (rx_done_tick) begin
                    b1_d    = rx_data;
                    cnt_d   = '0;
                    state_d = WAIT_B2;
                end else if (expired_c) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = WAIT_B0;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            WAIT_B2: begin
                if (rx_done_tick) begin
`ifdef MOUSE_OVF_CLAMP_EN
                    xm_d = axis_val(b0_q[3], ovf_q[0], b1_q);
                    ym_d = axis_val(b0_q[4], ovf_q[1], rx_data);
`else
                    xm_d = {b0_q[3], b1_q};
                    ym_d = {b0_q[4], rx_data};
`endif
                    btnm_d  = b0_q[2:0];
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_B0;
                end else if (expired_c) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = WAIT_B0;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = WAIT_B0;
            end
        endcase
    end

    assign xm          = xm_q;
    assign ym          = ym_q;
    assign btnm        = btnm_q;
    assign m_done_tick = done_q;
    assign sync_err    = err_q;

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Self-checking bench for ps2_mouse_packet: directed scenarios plus a
// randomized byte stream compared against a timestamp-based packet model.
module tb_ps2_mouse_packet;

    localparam int unsigned T = 1200;
    localparam int unsigned TW = 11;
`ifdef MOUSE_OVF_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic [8:0] xm, ym;
    logic [2:0] btnm;
    logic       m_done_tick, sync_err;

    int n_checks = 0;
    int n_fail = 0;

    ps2_mouse_packet #(.TIMEOUT_CYCLES(T), .TIMEOUT_W(TW)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
        .xm(xm), .ym(ym), .btnm(btnm), .m_done_tick(m_done_tick), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Reference model: bytes collected so far, time of last accepted byte.
    int          m_idx = 0;
    logic [7:0]  m_b0 = '0, m_b1 = '0;
    longint      m_now = 0, m_last = 0;
    logic [8:0]  e_xm = '0, e_ym = '0;
    logic [2:0]  e_btn = '0;
    logic        e_done = 1'b0, e_err = 1'b0;

    function automatic logic [8:0] model_axis(input logic sgn, input logic ovf, input logic [7:0] mag);
        if (CLAMP && ovf) return sgn ? 9'h101 : 9'h0FF;
        return {sgn, mag};
    endfunction

    always @(posedge clk) begin
        m_now  <= m_now + 1;
        e_done <= 1'b0;
        e_err  <= 1'b0;
        if (reset) begin
            m_idx <= 0;
            e_xm  <= '0;
            e_ym  <= '0;
            e_btn <= '0;
        end else if (rx_done_tick) begin
            if (m_idx == 0) begin
                if (rx_data[3]) begin
                    m_b0 <= rx_data; m_idx <= 1; m_last <= m_now + 1;
                end else begin
                    e_err <= 1'b1;
                end
            end else if (m_idx == 1) begin
                m_b1 <= rx_data; m_idx <= 2; m_last <= m_now + 1;
            end else begin
                e_xm   <= model_axis(m_b0[4], m_b0[6], m_b1);
                e_ym   <= model_axis(m_b0[5], m_b0[7], rx_data);
                e_btn  <= m_b0[2:0];
                e_done <= 1'b1;
                m_idx  <= 0;
            end
        end else if (m_idx != 0 && (m_now + 1 - m_last) == longint'(T)) begin
            m_idx <= 0;
            e_err <= 1'b1;
        end
    end

    // One clock: drive inputs at a falling edge, return at the next one.
    task automatic cyc(input logic v, input logic [7:0] d);
        rx_done_tick = v;
        rx_data      = d;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d);
        cyc(1'b1, d);
    endtask

    task automatic gap(input int n, output int nd, output int ne);
        nd = 0; ne = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 8'($urandom));
            nd += int'(m_done_tick);
            ne += int'(sync_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h09);
        n_checks++; if (xm !== 9'h000) begin n_fail++; $display("FAIL reset_xm got %h exp 000", xm); end
        n_checks++; if (ym !== 9'h000) begin n_fail++; $display("FAIL reset_ym got %h exp 000", ym); end
        n_checks++; if (btnm !== 3'b000) begin n_fail++; $display("FAIL reset_btn got %b exp 000", btnm); end
        n_checks++; if ({m_done_tick, sync_err} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses got %b exp 00", {m_done_tick, sync_err}); end
        reset = 1'b0;
        cyc(1'b0, 8'h00);
    endtask

    task automatic test_basic();
        int nd, ne, td, te;
        td = 0; te = 0;
        send(8'h09); gap(999, nd, ne); td += nd; te += ne;
        send(8'h05); gap(999, nd, ne); td += nd; te += ne;
        send(8'hFB);
        n_checks++; if (m_done_tick !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b exp 1", m_done_tick); end
        n_checks++; if (xm !== 9'h005) begin n_fail++; $display("FAIL basic_xm got %h exp 005", xm); end
        n_checks++; if (ym !== 9'h0FB) begin n_fail++; $display("FAIL basic_ym got %h exp 0fb", ym); end
        n_checks++; if (btnm !== 3'b001) begin n_fail++; $display("FAIL basic_btn got %b exp 001", btnm); end
        te += int'(sync_err);
        gap(5, nd, ne); td += nd; te += ne;
        n_checks++; if (td !== 0) begin n_fail++; $display("FAIL basic_extra_done got %0d exp 0", td); end
        n_checks++; if (te !== 0) begin n_fail++; $display("FAIL basic_sync_err got %0d exp 0", te); end
    endtask

    task automatic test_resync();
        send(8'h02);
        n_checks++; if (sync_err !== 1'b1) begin n_fail++; $display("FAIL resync_err got %b exp 1", sync_err); end
        send(8'h38);
        n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL resync_err_width got %b exp 0", sync_err); end
        send(8'h10); send(8'h20);
        n_checks++; if ({m_done_tick, xm, ym, btnm} !== {1'b1, 9'h110, 9'h120, 3'b000})
            begin n_fail++; $display("FAIL resync_pkt got done=%b xm=%h ym=%h btn=%b exp 1 110 120 000", m_done_tick, xm, ym, btnm); end
    endtask

    task automatic test_timeout();
        int nd, ne;
        send(8'h0A); send(8'h7F);
        gap(int'(T), nd, ne);
        n_checks++; if (ne !== 1) begin n_fail++; $display("FAIL timeout_err got %0d exp 1", ne); end
        n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL timeout_done got %0d exp 0", nd); end
        n_checks++; if ({xm, ym, btnm} !== {9'h110, 9'h120, 3'b000})
            begin n_fail++; $display("FAIL timeout_hold got xm=%h ym=%h btn=%b exp 110 120 000", xm, ym, btnm); end
        send(8'h0C); send(8'h01); send(8'h02);
        n_checks++; if ({m_done_tick, xm, ym, btnm} !== {1'b1, 9'h001, 9'h002, 3'b100})
            begin n_fail++; $display("FAIL timeout_next got done=%b xm=%h ym=%h btn=%b exp 1 001 002 100", m_done_tick, xm, ym, btnm); end
    endtask

    task automatic test_overflow();
        logic [8:0] exp_x;
        exp_x = CLAMP ? 9'h101 : 9'h180;
        send(8'h59); send(8'h80); send(8'h00);
        n_checks++; if ({m_done_tick, xm, ym, btnm} !== {1'b1, exp_x, 9'h000, 3'b001})
            begin n_fail++; $display("FAIL ovf_pkt got done=%b xm=%h ym=%h btn=%b exp 1 %h 000 001", m_done_tick, xm, ym, btnm, exp_x); end
    endtask

    task automatic test_reset_mid();
        int nd, ne;
        send(8'h0B); send(8'h03);
        reset = 1'b1; cyc(1'b0, 8'h00); reset = 1'b0;
        n_checks++; if ({xm, ym, btnm} !== 21'd0) begin n_fail++; $display("FAIL rstmid_clear got xm=%h ym=%h btn=%b exp 0", xm, ym, btnm); end
        send(8'h0B); send(8'h03);
        n_checks++; if (m_done_tick !== 1'b0) begin n_fail++; $display("FAIL rstmid_early_done got %b exp 0", m_done_tick); end
        send(8'h04);
        n_checks++; if ({m_done_tick, xm, ym, btnm} !== {1'b1, 9'h003, 9'h004, 3'b011})
            begin n_fail++; $display("FAIL rstmid_pkt got done=%b xm=%h ym=%h btn=%b exp 1 003 004 011", m_done_tick, xm, ym, btnm); end
        gap(4, nd, ne);
        n_checks++; if (nd + ne !== 0) begin n_fail++; $display("FAIL rstmid_after got %0d pulses exp 0", nd + ne); end
    endtask

    task automatic test_timeout_edge();
        int nd, ne;
        send(8'h08); send(8'h01);
        gap(int'(T) - 1, nd, ne);
        send(8'h02);
        n_checks++; if ({m_done_tick, sync_err} !== 2'b10) begin n_fail++; $display("FAIL edge_accept got done/err=%b exp 10", {m_done_tick, sync_err}); end
        n_checks++; if ({ne, xm, ym} !== {32'd0, 9'h001, 9'h002}) begin n_fail++; $display("FAIL edge_pkt got err=%0d xm=%h ym=%h exp 0 001 002", ne, xm, ym); end
        send(8'h08); send(8'h01);
        gap(int'(T), nd, ne);
        send(8'h02);
        n_checks++; if (ne !== 1 || sync_err !== 1'b1 || m_done_tick !== 1'b0)
            begin n_fail++; $display("FAIL edge_late got err=%0d now_err=%b done=%b exp 1 1 0", ne, sync_err, m_done_tick); end
    endtask

    task automatic test_back_to_back();
        send(8'h09); send(8'h05); send(8'hFB);
        n_checks++; if ({m_done_tick, xm, ym} !== {1'b1, 9'h005, 9'h0FB}) begin n_fail++; $display("FAIL b2b_first got done=%b xm=%h ym=%h exp 1 005 0fb", m_done_tick, xm, ym); end
        send(8'h0C);
        n_checks++; if (m_done_tick !== 1'b0) begin n_fail++; $display("FAIL b2b_done_width got %b exp 0", m_done_tick); end
        send(8'h01); send(8'h02);
        n_checks++; if ({m_done_tick, xm, ym, btnm} !== {1'b1, 9'h001, 9'h002, 3'b100}) begin n_fail++; $display("FAIL b2b_second got done=%b xm=%h ym=%h btn=%b exp 1 001 002 100", m_done_tick, xm, ym, btnm); end
    endtask

    task automatic test_random();
        int len, r;
        for (int ev = 0; ev < 250; ev++) begin
            r = int'($urandom_range(0, 31));
            if (r == 0)      len = int'(T) - 2 + int'($urandom_range(0, 2));
            else if (r < 12) len = 0;
            else             len = int'($urandom_range(1, 6));
            for (int c = 0; c <= len; c++) begin
                reset = (r == 31 && c == 0);
                cyc(c == len, 8'($urandom));
                n_checks++;
                if ({xm, ym, btnm, m_done_tick, sync_err} !== {e_xm, e_ym, e_btn, e_done, e_err}) begin
                    n_fail++;
                    $display("FAIL rand ev%0d got xm=%h ym=%h btn=%b done=%b err=%b exp %h %h %b %b %b",
                             ev, xm, ym, btnm, m_done_tick, sync_err, e_xm, e_ym, e_btn, e_done, e_err);
                end
                n_checks++;
                if ((m_done_tick & sync_err) !== 1'b0) begin n_fail++; $display("FAIL rand_both ev%0d got 1 exp 0", ev); end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rx_done_tick = 1'b0;
        rx_data = 8'h00;
        @(negedge clk);
        test_reset();
        test_basic();
        test_resync();
        test_timeout();
        test_overflow();
        test_reset_mid();
        test_timeout_edge();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
